// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer front end.
//   i2s_state_t    : receive sequencer states
//   SMPL_W         : default audio sample width
//   I2S_DELAY_BITS : SCLK periods between an LRCLK edge and the sample MSB
package eq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT
  } i2s_state_t;

  localparam int unsigned SMPL_W         = 24;
  localparam int unsigned I2S_DELAY_BITS = 1;

endpackage

// File: rtl/i2s_shift_reg.sv
// MSB-first deserializer for one I2S slot.
//   clk, rst  : system clock, synchronous active-high reset
//   clr       : clears the register (slot entry / framing loss)
//   shift_en  : shifts sdata into the LSB
//   sdata     : serial input bit
//   q_shift   : value the register takes on a shift (current contents
//               moved left with sdata appended); the controller latches
//               this directly when the final bit of a word arrives
module i2s_shift_reg #(
  parameter int unsigned DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic              sdata,
  output logic [DATA_W-1:0] q_shift
);

  logic [DATA_W-1:0] q;

  assign q_shift = {q[DATA_W-2:0], sdata};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (shift_en) begin
      q <= q_shift;
    end
  end

endmodule

// File: rtl/i2s_rx_ctrl.sv
// I2S receive sequencer: frames SCLK/LRCLK edge pulses, deserializes one
// left and one right sample per LRCLK period and presents the pair with a
// one-cycle valid strobe.
//   clk, rst   : system clock, synchronous active-high reset
//   sclk_rise  : SCLK rising-edge pulse
//   lrclk_fall : LRCLK falling-edge pulse (left slot start)
//   lrclk_rise : LRCLK rising-edge pulse (right slot start)
//   sdata      : serial data, sampled with sclk_rise
//   lft_smpl   : last complete left sample
//   rght_smpl  : last complete right sample
//   smpl_vld   : one-cycle strobe, new coherent sample pair
//   sync_err   : one-cycle strobe, framing violation
//   locked     : frames are being accepted
module i2s_rx_ctrl
  import eq_pkg::*;
#(
  parameter int unsigned DATA_W   = SMPL_W,
  parameter int unsigned MIN_SLOT = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk_rise,
  input  logic              lrclk_fall,
  input  logic              lrclk_rise,
  input  logic              sdata,
  output logic [DATA_W-1:0] lft_smpl,
  output logic [DATA_W-1:0] rght_smpl,
  output logic              smpl_vld,
  output logic              sync_err,
  output logic              locked
);

  localparam int unsigned      CNT_W    = $clog2(MIN_SLOT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] MIN_C    = CNT_W'(MIN_SLOT);
  localparam logic [CNT_W-1:0] DATA_C   = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(I2S_DELAY_BITS);

  i2s_state_t        state, state_nxt;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] left_hold;
  logic [DATA_W-1:0] sr_shift;
  logic              lr_edge, slot_full;
  logic              slot_start, frame_err;
  logic              shift_en, last_bit, sr_clr;
  logic              vld_pend;

  assign lr_edge   = lrclk_fall | lrclk_rise;
  assign slot_full = (bit_cnt >= MIN_C);

  always_comb begin
    state_nxt  = state;
    slot_start = 1'b0;
    frame_err  = 1'b0;
    case (state)
      IDLE: begin
        if (lrclk_fall && lrclk_rise) begin
          frame_err = 1'b1;
        end else if (lrclk_fall) begin
          state_nxt  = LEFT;
          slot_start = 1'b1;
        end
      end
      LEFT: begin
        if (lr_edge) begin
          if (lrclk_rise && !lrclk_fall && slot_full) begin
            state_nxt  = RIGHT;
            slot_start = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      RIGHT: begin
        if (lr_edge) begin
          if (lrclk_fall && !lrclk_rise && slot_full) begin
            state_nxt  = LEFT;
            slot_start = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A violating edge never starts a slot; it only returns to IDLE.
    if (frame_err) begin
      state_nxt  = IDLE;
      slot_start = 1'b0;
    end
  end

  // An sclk_rise coinciding with an LRCLK edge is the new slot's delay bit,
  // so it never shifts.
  assign shift_en = (state != IDLE) && !lr_edge && sclk_rise &&
                    (bit_cnt >= DELAY_C) && (bit_cnt <= DATA_C);
  assign last_bit = shift_en && (bit_cnt == DATA_C);
  assign sr_clr   = slot_start || frame_err || (state == IDLE);

  i2s_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr      (sr_clr),
    .shift_en (shift_en),
    .sdata    (sdata),
    .q_shift  (sr_shift)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      left_hold <= '0;
      lft_smpl  <= '0;
      rght_smpl <= '0;
      vld_pend  <= 1'b0;
      smpl_vld  <= 1'b0;
      sync_err  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state    <= state_nxt;
      sync_err <= frame_err;
      vld_pend <= 1'b0;
      smpl_vld <= vld_pend;

      if (slot_start) begin
        bit_cnt <= {{(CNT_W-1){1'b0}}, sclk_rise};
      end else if ((state == IDLE) || frame_err) begin
        bit_cnt <= '0;
      end else if (sclk_rise && (bit_cnt != CNT_MAX)) begin
        bit_cnt <= bit_cnt + 1'b1;
      end

      if (last_bit) begin
        if (state == LEFT) begin
          left_hold <= sr_shift;
        end else begin
          lft_smpl  <= left_hold;
          rght_smpl <= sr_shift;
          vld_pend  <= 1'b1;
        end
      end

      if (frame_err) begin
        left_hold <= '0;
        locked    <= 1'b0;
      end else if (vld_pend) begin
        locked <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Self-checking bench for i2s_rx_ctrl. Frames are described by the words
// sent and the SCLK count per half; the expected sample pairs are derived
// from those words alone.
module tb_i2s_rx_ctrl;

  logic        clk;
  logic        rst;
  logic        sclk_rise;
  logic        lrclk_fall;
  logic        lrclk_rise;
  logic        sdata;
  logic [23:0] lft_smpl;
  logic [23:0] rght_smpl;
  logic        smpl_vld;
  logic        sync_err;
  logic        locked;

  int errors = 0;
  int checks = 0;

  logic [47:0] obs_q[$];
  int          err_cycles = 0;

  i2s_rx_ctrl #(
    .DATA_W   (24),
    .MIN_SLOT (24)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sclk_rise  (sclk_rise),
    .lrclk_fall (lrclk_fall),
    .lrclk_rise (lrclk_rise),
    .sdata      (sdata),
    .lft_smpl   (lft_smpl),
    .rght_smpl  (rght_smpl),
    .smpl_vld   (smpl_vld),
    .sync_err   (sync_err),
    .locked     (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (smpl_vld) obs_q.push_back({lft_smpl, rght_smpl});
    if (sync_err) err_cycles++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic r, input logic s, input logic d);
    lrclk_fall = f;
    lrclk_rise = r;
    sclk_rise  = s;
    sdata      = d;
    tick();
    lrclk_fall = 1'b0;
    lrclk_rise = 1'b0;
    sclk_rise  = 1'b0;
    sdata      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // One half-frame: LRCLK edge, then n SCLK rising edges in total (delay bit
  // included). With coin=1 the first SCLK coincides with the LRCLK edge.
  task automatic send_half(input bit is_right, input logic [23:0] w,
                           input int n, input bit coin);
    int   k;
    logic d;
    if (coin) begin
      drive(!is_right, is_right, 1'b1, 1'($urandom));
      k = 1;
    end else begin
      drive(!is_right, is_right, 1'b0, 1'b0);
      k = 0;
    end
    while (k < n) begin
      repeat ($urandom_range(0, 2)) tick();
      if (k >= 1 && k <= 24) d = w[24-k];
      else d = 1'($urandom);
      drive(1'b0, 1'b0, 1'b1, d);
      k++;
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r,
                            input int nl, input int nr, input bit coin);
    send_half(1'b0, l, nl, coin);
    send_half(1'b1, r, nr, coin);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    lrclk_fall = 1'b1;
    sclk_rise  = 1'b1;
    sdata      = 1'b1;
    tick();
    tick();
    lrclk_fall = 1'b0;
    sclk_rise  = 1'b0;
    sdata      = 1'b0;
    checks++; if (lft_smpl !== 24'h0) begin errors++; $display("FAIL reset_lft: got %h expected 000000", lft_smpl); end
    checks++; if (rght_smpl !== 24'h0) begin errors++; $display("FAIL reset_rght: got %h expected 000000", rght_smpl); end
    checks++; if (smpl_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", smpl_vld); end
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", sync_err); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
    rst = 1'b0;
  endtask

  task automatic test_standard();
    int base, ebase;
    do_reset();
    base  = obs_q.size();
    ebase = err_cycles;
    send_frame(24'hA5A5A5, 24'h5A5A5A, 32, 32, 1'b0);
    idle(6);
    checks++; if (obs_q.size() - base !== 1) begin errors++; $display("FAIL std_strobes: got %0d expected 1", obs_q.size() - base); end
    if (obs_q.size() > base) begin
      checks++; if (obs_q[base] !== {24'hA5A5A5, 24'h5A5A5A}) begin errors++; $display("FAIL std_pair: got %h expected a5a5a55a5a5a", obs_q[base]); end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL std_locked: got %b expected 1", locked); end
    checks++; if (err_cycles - ebase !== 0) begin errors++; $display("FAIL std_err: got %0d expected 0", err_cycles - ebase); end
  endtask

  task automatic test_startup_mid();
    int base, ebase;
    logic [23:0] l, r;
    do_reset();
    base  = obs_q.size();
    ebase = err_cycles;
    send_half(1'b1, 24'($urandom), 32, 1'b0);
    idle(4);
    checks++; if (obs_q.size() - base !== 0) begin errors++; $display("FAIL mid_early_strobe: got %0d expected 0", obs_q.size() - base); end
    l = 24'($urandom);
    r = 24'($urandom);
    send_half(1'b0, l, 32, 1'b0);
    idle(4);
    checks++; if (obs_q.size() - base !== 0) begin errors++; $display("FAIL mid_left_only: got %0d expected 0", obs_q.size() - base); end
    send_half(1'b1, r, 32, 1'b0);
    idle(6);
    checks++; if (obs_q.size() - base !== 1) begin errors++; $display("FAIL mid_strobes: got %0d expected 1", obs_q.size() - base); end
    if (obs_q.size() > base) begin
      checks++; if (obs_q[base] !== {l, r}) begin errors++; $display("FAIL mid_pair: got %h expected %h", obs_q[base], {l, r}); end
    end
    checks++; if (err_cycles - ebase !== 0) begin errors++; $display("FAIL mid_err: got %0d expected 0", err_cycles - ebase); end
  endtask

  task automatic test_short_slot();
    int base, ebase;
    logic [23:0] l, r;
    do_reset();
    send_frame(24'h111111, 24'h222222, 32, 32, 1'b0);
    base  = obs_q.size();
    ebase = err_cycles;
    send_half(1'b0, 24'h333333, 10, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (sync_err !== 1'b1) begin errors++; $display("FAIL short_err_pulse: got %b expected 1", sync_err); end
    tick();
    checks++; if (sync_err !== 1'b0) begin errors++; $display("FAIL short_err_width: got %b expected 0", sync_err); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL short_locked: got %b expected 0", locked); end
    send_half(1'b1, 24'h444444, 32, 1'b0);
    idle(4);
    checks++; if (obs_q.size() - base !== 0) begin errors++; $display("FAIL short_no_strobe: got %0d expected 0", obs_q.size() - base); end
    checks++; if (err_cycles - ebase !== 1) begin errors++; $display("FAIL short_err_count: got %0d expected 1", err_cycles - ebase); end
    l = 24'($urandom);
    r = 24'($urandom);
    send_frame(l, r, 32, 32, 1'b0);
    idle(6);
    checks++; if (obs_q.size() - base !== 1) begin errors++; $display("FAIL short_recover_strobes: got %0d expected 1", obs_q.size() - base); end
    if (obs_q.size() > base) begin
      checks++; if (obs_q[base] !== {l, r}) begin errors++; $display("FAIL short_recover_pair: got %h expected %h", obs_q[base], {l, r}); end
    end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL short_relock: got %b expected 1", locked); end
  endtask

  // 24 SCLKs in a half is the shortest legal slot (word incomplete, left
  // holding register untouched); 23 is a violation, as is lrclk_fall in LEFT.
  task automatic test_slot_boundary();
    int base, ebase;
    logic [23:0] r;
    do_reset();
    base  = obs_q.size();
    ebase = err_cycles;
    r = 24'($urandom);
    send_frame(24'hFFFFFF, r, 24, 25, 1'b0);
    idle(6);
    checks++; if (err_cycles - ebase !== 0) begin errors++; $display("FAIL bnd24_err: got %0d expected 0", err_cycles - ebase); end
    checks++; if (obs_q.size() - base !== 1) begin errors++; $display("FAIL bnd25_strobes: got %0d expected 1", obs_q.size() - base); end
    if (obs_q.size() > base) begin
      checks++; if (obs_q[base] !== {24'h0, r}) begin errors++; $display("FAIL bnd_pair: got %h expected %h", obs_q[base], {24'h0, r}); end
    end
    send_half(1'b0, 24'h123456, 23, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    checks++; if (err_cycles - ebase !== 1) begin errors++; $display("FAIL bnd23_err: got %0d expected 1", err_cycles - ebase); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL bnd23_locked: got %b expected 0", locked); end
    send_half(1'b0, 24'h123456, 30, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    checks++; if (err_cycles - ebase !== 2) begin errors++; $display("FAIL fall_in_left_err: got %0d expected 2", err_cycles - ebase); end
  endtask

  task automatic test_coincident();
    int base;
    logic [23:0] r;
    do_reset();
    base = obs_q.size();
    r = 24'($urandom);
    send_frame(24'h800001, r, 32, 32, 1'b1);
    idle(6);
    checks++; if (obs_q.size() - base !== 1) begin errors++; $display("FAIL coin_strobes: got %0d expected 1", obs_q.size() - base); end
    checks++; if (lft_smpl !== 24'h800001) begin errors++; $display("FAIL coin_lft: got %h expected 800001", lft_smpl); end
    checks++; if (rght_smpl !== r) begin errors++; $display("FAIL coin_rght: got %h expected %h", rght_smpl, r); end
  endtask

  task automatic test_reset_mid_right();
    int base;
    do_reset();
    send_frame(24'h123456, 24'h654321, 32, 32, 1'b0);
    idle(4);
    base = obs_q.size();
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL rmid_pre_locked: got %b expected 1", locked); end
    send_half(1'b0, 24'hABCDEF, 32, 1'b0);
    send_half(1'b1, 24'hFEDCBA, 13, 1'b0);
    rst = 1'b1;
    tick();
    checks++; if ({lft_smpl, rght_smpl} !== 48'h0) begin errors++; $display("FAIL rmid_samples: got %h expected 0", {lft_smpl, rght_smpl}); end
    checks++; if ({smpl_vld, sync_err, locked} !== 3'b000) begin errors++; $display("FAIL rmid_flags: got %b expected 000", {smpl_vld, sync_err, locked}); end
    rst = 1'b0;
    repeat (20) drive(1'b0, 1'b0, 1'b1, 1'b1);
    idle(4);
    checks++; if (obs_q.size() - base !== 0) begin errors++; $display("FAIL rmid_strobes: got %0d expected 0", obs_q.size() - base); end
  endtask

  task automatic test_back_to_back();
    int base, ebase;
    logic [47:0] exp_pair;
    do_reset();
    base  = obs_q.size();
    ebase = err_cycles;
    for (int f = 0; f < 4; f++) begin
      send_frame(24'(2 * f + 1), 24'(2 * f + 2), 32, 32, 1'b0);
    end
    idle(6);
    checks++; if (obs_q.size() - base !== 4) begin errors++; $display("FAIL b2b_strobes: got %0d expected 4", obs_q.size() - base); end
    for (int f = 0; f < 4; f++) begin
      exp_pair = {24'(2 * f + 1), 24'(2 * f + 2)};
      if (base + f < obs_q.size()) begin
        checks++; if (obs_q[base + f] !== exp_pair) begin errors++; $display("FAIL b2b_pair%0d: got %h expected %h", f, obs_q[base + f], exp_pair); end
      end
    end
    checks++; if (err_cycles - ebase !== 0) begin errors++; $display("FAIL b2b_err: got %0d expected 0", err_cycles - ebase); end
  endtask

  // Reference: a half delivers its word only if it carries all 24 data bits
  // (>= 25 SCLKs); a pair is presented once the right word completes, using
  // the most recent complete left word (0 after reset).
  task automatic test_random();
    int base, ebase, nl, nr;
    bit coin;
    logic [23:0] l, r, hold;
    logic [47:0] exp_q[$];
    do_reset();
    base  = obs_q.size();
    ebase = err_cycles;
    hold  = 24'h0;
    for (int f = 0; f < 20; f++) begin
      l    = 24'($urandom);
      r    = 24'($urandom);
      nl   = $urandom_range(24, 32);
      nr   = $urandom_range(24, 32);
      coin = 1'($urandom);
      send_frame(l, r, nl, nr, coin);
      if (nl >= 25) hold = l;
      if (nr >= 25) exp_q.push_back({hold, r});
    end
    idle(6);
    checks++; if (obs_q.size() - base !== exp_q.size()) begin errors++; $display("FAIL rnd_strobes: got %0d expected %0d", obs_q.size() - base, exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < obs_q.size()) begin
        checks++; if (obs_q[base + i] !== exp_q[i]) begin errors++; $display("FAIL rnd_pair%0d: got %h expected %h", i, obs_q[base + i], exp_q[i]); end
      end
    end
    checks++; if (err_cycles - ebase !== 0) begin errors++; $display("FAIL rnd_err: got %0d expected 0", err_cycles - ebase); end
  endtask

  initial begin
    rst        = 1'b1;
    sclk_rise  = 1'b0;
    lrclk_fall = 1'b0;
    lrclk_rise = 1'b0;
    sdata      = 1'b0;
    tick();
    test_reset();
    test_standard();
    test_startup_mid();
    test_short_slot();
    test_slot_boundary();
    test_coincident();
    test_reset_mid_right();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
